// File: rtl/risc16_pkg.sv
// Shared widths and the operand bundle handed from operand fetch to execute.
package risc16_pkg;

  localparam int p_WORD_LEN      = 16;
  localparam int p_REG_ADDR_LEN  = 3;
  localparam int p_REG_FILE_SIZE = 8;
  localparam int p_PEND_BITS     = 2;

  typedef struct packed {
    logic [p_WORD_LEN-1:0]     src1_data;
    logic [p_WORD_LEN-1:0]     src2_data;
    logic [p_REG_ADDR_LEN-1:0] tgt;
    logic                      tgt_en;
  } operand_bundle_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters: issue claims, writeback retires,
// flush kills a claim; also reports source RAW blocks and target saturation.
module reg_scoreboard
  import risc16_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [p_REG_ADDR_LEN-1:0] i_src1,
  input  logic [p_REG_ADDR_LEN-1:0] i_src2,
  input  logic [p_REG_ADDR_LEN-1:0] i_tgt,
  input  logic                      i_tgt_en,
  input  logic                      i_accept,
  input  logic                      i_wb_valid,
  input  logic [p_REG_ADDR_LEN-1:0] i_wb_tgt,
  input  logic                      i_kill,
  input  logic [p_REG_ADDR_LEN-1:0] i_kill_tgt,
  output logic                      o_src1_blocked,
  output logic                      o_src2_blocked,
  output logic                      o_tgt_sat,
  output logic                      o_err
);

  localparam logic [p_PEND_BITS-1:0] PEND_MAX = '1;

  logic [p_PEND_BITS-1:0] pend_q [p_REG_FILE_SIZE];
  logic [p_PEND_BITS-1:0] pend_d [p_REG_FILE_SIZE];
  logic                   err_q, err_d;
  logic                   wb_hit1, wb_hit2, wb_hit_tgt;

  assign wb_hit1    = i_wb_valid && (i_wb_tgt == i_src1);
  assign wb_hit2    = i_wb_valid && (i_wb_tgt == i_src2);
  assign wb_hit_tgt = i_wb_valid && (i_wb_tgt == i_tgt);

  // A same-cycle writeback retires one claim, so "pend > hit" means a write is still owed.
  assign o_src1_blocked = (i_src1 != '0) && (pend_q[i_src1] > p_PEND_BITS'(wb_hit1));
  assign o_src2_blocked = (i_src2 != '0) && (pend_q[i_src2] > p_PEND_BITS'(wb_hit2));
  assign o_tgt_sat      = i_tgt_en && (i_tgt != '0) && (pend_q[i_tgt] == PEND_MAX) && !wb_hit_tgt;
  assign o_err          = err_q;

  always_comb begin
    // NOTE: defaulting every always_comb output up front keeps any path from inferring a latch.
    pend_d = pend_q;
    err_d  = err_q;
    for (int r = 1; r < p_REG_FILE_SIZE; r++) begin : g_net
      logic [p_REG_ADDR_LEN-1:0] r_addr;
      logic                      kill, wb_hit, inc, dec;
      logic [p_PEND_BITS-1:0]    avail;
      r_addr = p_REG_ADDR_LEN'(r);
      kill   = i_kill && (i_kill_tgt == r_addr) && (pend_q[r] != '0);
      avail  = pend_q[r] - p_PEND_BITS'(kill);
      wb_hit = i_wb_valid && (i_wb_tgt == r_addr);
      inc    = i_accept && i_tgt_en && (i_tgt == r_addr);
      dec    = wb_hit && (avail != '0);
      if (wb_hit && (avail == '0)) err_d = 1'b1;
      if (inc && !dec)      pend_d[r] = (avail == PEND_MAX) ? PEND_MAX : avail + 1'b1;
      else if (dec && !inc) pend_d[r] = avail - 1'b1;
      else                  pend_d[r] = avail;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the counter array is architectural state that gates issue, so every entry is reset.
      for (int r = 0; r < p_REG_FILE_SIZE; r++) pend_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: rtl/reg_operand_fetch.sv
// RiSC-16 operand fetch: register-file port pass-through, writeback bypass,
// scoreboard-gated issue and a single registered output slot toward execute.
module reg_operand_fetch
  import risc16_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [p_REG_ADDR_LEN-1:0] i_src1,
  input  logic [p_REG_ADDR_LEN-1:0] i_src2,
  input  logic [p_REG_ADDR_LEN-1:0] i_tgt,
  input  logic                      i_tgt_en,
  output logic [p_REG_ADDR_LEN-1:0] o_rf_src1,
  output logic [p_REG_ADDR_LEN-1:0] o_rf_src2,
  input  logic [p_WORD_LEN-1:0]     i_rf_src1_data,
  input  logic [p_WORD_LEN-1:0]     i_rf_src2_data,
  input  logic                      i_wb_valid,
  input  logic [p_REG_ADDR_LEN-1:0] i_wb_tgt,
  input  logic [p_WORD_LEN-1:0]     i_wb_data,
  output logic [p_REG_ADDR_LEN-1:0] o_rf_tgt,
  output logic [p_WORD_LEN-1:0]     o_rf_tgt_data,
  output logic                      o_rf_wr_en,
  input  logic                      i_flush,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [p_WORD_LEN-1:0]     o_src1_data,
  output logic [p_WORD_LEN-1:0]     o_src2_data,
  output logic [p_REG_ADDR_LEN-1:0] o_tgt,
  output logic                      o_tgt_en,
  output logic                      o_err
);

  operand_bundle_t       bundle_q, bundle_d;
  logic                  valid_q, valid_d;
  logic                  src1_blocked, src2_blocked, tgt_sat;
  logic                  slot_free, accept, kill;
  logic [p_WORD_LEN-1:0] src1_eff, src2_eff;

  function automatic logic [p_WORD_LEN-1:0] bypass(
    input logic [p_REG_ADDR_LEN-1:0] src,
    input logic [p_WORD_LEN-1:0]     rf_data,
    input logic                      wb_valid,
    input logic [p_REG_ADDR_LEN-1:0] wb_tgt,
    input logic [p_WORD_LEN-1:0]     wb_data
  );
    if (src == '0)                        return '0;
    else if (wb_valid && (wb_tgt == src)) return wb_data;
    else                                  return rf_data;
  endfunction

  assign o_rf_src1     = i_src1;
  assign o_rf_src2     = i_src2;
  assign o_rf_tgt      = i_wb_tgt;
  assign o_rf_tgt_data = i_wb_data;
  assign o_rf_wr_en    = i_wb_valid;

  assign src1_eff = bypass(i_src1, i_rf_src1_data, i_wb_valid, i_wb_tgt, i_wb_data);
  assign src2_eff = bypass(i_src2, i_rf_src2_data, i_wb_valid, i_wb_tgt, i_wb_data);

  assign slot_free = !valid_q || i_ready || i_flush;
  assign o_ready   = !src1_blocked && !src2_blocked && !tgt_sat && slot_free;
  assign accept    = i_valid && o_ready;
  // A flushed bundle will never write back, so its scoreboard claim is returned here.
  assign kill      = i_flush && valid_q && bundle_q.tgt_en;

  reg_scoreboard u_scoreboard (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_src1         (i_src1),
    .i_src2         (i_src2),
    .i_tgt          (i_tgt),
    .i_tgt_en       (i_tgt_en),
    .i_accept       (accept),
    .i_wb_valid     (i_wb_valid),
    .i_wb_tgt       (i_wb_tgt),
    .i_kill         (kill),
    .i_kill_tgt     (bundle_q.tgt),
    .o_src1_blocked (src1_blocked),
    .o_src2_blocked (src2_blocked),
    .o_tgt_sat      (tgt_sat),
    .o_err          (o_err)
  );

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (accept) begin
      valid_d  = 1'b1;
      bundle_d = '{src1_data: src1_eff, src2_data: src2_eff, tgt: i_tgt, tgt_en: i_tgt_en};
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_src1_data = bundle_q.src1_data;
  assign o_src2_data = bundle_q.src2_data;
  assign o_tgt       = bundle_q.tgt;
  assign o_tgt_en    = bundle_q.tgt_en;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// then randomized traffic against a counting reference model.
module tb_reg_operand_fetch;

  typedef struct packed {
    logic        valid;
    logic [2:0]  src1, src2, tgt;
    logic        tgt_en;
    logic [15:0] rf1, rf2;
    logic        wb_valid;
    logic [2:0]  wb_tgt;
    logic [15:0] wb_data;
    logic        flush, rdy;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic        exp_ready, exp_valid;
    logic [15:0] exp_d1, exp_d2;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid, ready_o, tgt_en, wb_valid, flush, rdy, rf_wr_en, valid_o, tgt_en_o, err_o;
  logic [2:0]  src1, src2, tgt, rf_src1, rf_src2, wb_tgt, rf_tgt, tgt_o;
  logic [15:0] rf1, rf2, wb_data, rf_tgt_data, d1_o, d2_o;

  int n_cmp = 0, n_fail = 0;

  // reference model: outstanding write count per register, output slot, error flag, register contents
  int          pend [8];
  logic        m_valid, m_tgt_en, m_err;
  logic [2:0]  m_tgt;
  logic [15:0] m_d1, m_d2;
  logic [15:0] rf_mem [8];

  always #5 clk = ~clk;

  reg_operand_fetch dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_o),
    .i_src1(src1), .i_src2(src2), .i_tgt(tgt), .i_tgt_en(tgt_en),
    .o_rf_src1(rf_src1), .o_rf_src2(rf_src2),
    .i_rf_src1_data(rf1), .i_rf_src2_data(rf2),
    .i_wb_valid(wb_valid), .i_wb_tgt(wb_tgt), .i_wb_data(wb_data),
    .o_rf_tgt(rf_tgt), .o_rf_tgt_data(rf_tgt_data), .o_rf_wr_en(rf_wr_en),
    .i_flush(flush), .o_valid(valid_o), .i_ready(rdy),
    .o_src1_data(d1_o), .o_src2_data(d2_o), .o_tgt(tgt_o), .o_tgt_en(tgt_en_o),
    .o_err(err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic v, input logic [2:0] s1, s2, t, input logic te,
                               input logic [15:0] r1, r2, input logic wv, input logic [2:0] wt,
                               input logic [15:0] wd);
    return '{valid: v, src1: s1, src2: s2, tgt: t, tgt_en: te, rf1: r1, rf2: r2,
             wb_valid: wv, wb_tgt: wt, wb_data: wd, flush: 1'b0, rdy: 1'b1};
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0);
  endfunction

  function automatic logic [15:0] eff(input logic [2:0] src, input logic [15:0] rf, input stim_t s);
    if (src == 0) return 16'h0;
    if (s.wb_valid && s.wb_tgt == src) return s.wb_data;
    return rf;
  endfunction

  function automatic logic model_ready(input stim_t s);
    int h1, h2;
    logic b1, b2, bt, free;
    h1   = (s.wb_valid && s.wb_tgt == s.src1) ? 1 : 0;
    h2   = (s.wb_valid && s.wb_tgt == s.src2) ? 1 : 0;
    b1   = (s.src1 != 0) && (pend[s.src1] - h1 > 0);
    b2   = (s.src2 != 0) && (pend[s.src2] - h2 > 0);
    bt   = s.tgt_en && (s.tgt != 0) && (pend[s.tgt] == 3) && !(s.wb_valid && s.wb_tgt == s.tgt);
    free = !m_valid || s.rdy || s.flush;
    return !b1 && !b2 && !bt && free;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) pend[r] = 0;
    m_valid = 0; m_tgt_en = 0; m_err = 0; m_tgt = 0; m_d1 = 0; m_d2 = 0;
  endtask

  task automatic model_edge(input stim_t s, input logic acc);
    logic killen;
    int   kr, av, n, inc, wbh;
    killen = s.flush && m_valid && m_tgt_en;
    kr     = m_tgt;
    for (int r = 1; r < 8; r++) begin
      av  = pend[r] - ((killen && kr == r) ? 1 : 0);
      if (av < 0) av = 0;
      wbh = (s.wb_valid && s.wb_tgt == r) ? 1 : 0;
      inc = (acc && s.tgt_en && s.tgt == r) ? 1 : 0;
      if (wbh == 1 && av == 0) m_err = 1'b1;
      n = av + inc - ((wbh == 1 && av > 0) ? 1 : 0);
      if (n < 0) n = 0;
      if (n > 3) n = 3;
      pend[r] = n;
    end
    if (acc) begin
      m_valid = 1'b1;
      m_d1 = eff(s.src1, s.rf1, s); m_d2 = eff(s.src2, s.rf2, s);
      m_tgt = s.tgt; m_tgt_en = s.tgt_en;
    end else if (!m_valid || s.rdy || s.flush) begin
      m_valid = 1'b0;
    end
    if (s.wb_valid && s.wb_tgt != 0) rf_mem[s.wb_tgt] = s.wb_data;
  endtask

  task automatic drive(input stim_t s);
    valid = s.valid; src1 = s.src1; src2 = s.src2; tgt = s.tgt; tgt_en = s.tgt_en;
    rf1 = s.rf1; rf2 = s.rf2; wb_valid = s.wb_valid; wb_tgt = s.wb_tgt; wb_data = s.wb_data;
    flush = s.flush; rdy = s.rdy;
  endtask

  // one clock: drive at the falling edge, check combinational outputs, then registered outputs after the rise
  task automatic step(input stim_t s, output logic got_ready);
    logic exp_r;
    drive(s);
    #1;
    exp_r     = model_ready(s);
    got_ready = ready_o;
    check("ready", 64'(ready_o), 64'(exp_r));
    check("rf_passthru", 64'({rf_src1, rf_src2, rf_tgt, rf_tgt_data, rf_wr_en}),
          64'({s.src1, s.src2, s.wb_tgt, s.wb_data, s.wb_valid}));
    @(posedge clk);
    model_edge(s, s.valid && exp_r);
    #1;
    check("valid", 64'(valid_o), 64'(m_valid));
    check("err", 64'(err_o), 64'(m_err));
    if (m_valid) check("bundle", 64'({d1_o, d2_o, tgt_o, tgt_en_o}), 64'({m_d1, m_d2, m_tgt, m_tgt_en}));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(idle());
    @(negedge clk);
    model_reset();
    check("rst_state", 64'({valid_o, err_o, tgt_en_o, d1_o, d2_o, tgt_o}), 64'h0);
    check("rst_ready", 64'(ready_o), 64'h1);
    rst_n = 1'b1;
  endtask

  vec_t  tab [13];
  stim_t s;
  logic  r_got;

  initial begin
    for (int r = 0; r < 8; r++) rf_mem[r] = 16'h0;
    tab[0]  = '{mk(1,3'd1,3'd2,3'd0,0,16'h1111,16'h2222,0,3'd0,16'h0), 1'b1, 1'b1, 16'h1111, 16'h2222};
    tab[1]  = '{mk(1,3'd0,3'd0,3'd3,1,16'hFFFF,16'hFFFF,0,3'd0,16'h0), 1'b1, 1'b1, 16'h0000, 16'h0000};
    tab[2]  = '{mk(1,3'd3,3'd0,3'd0,0,16'h1234,16'h0000,0,3'd0,16'h0), 1'b0, 1'b0, 16'h0000, 16'h0000};
    tab[3]  = '{mk(1,3'd3,3'd0,3'd0,0,16'h1234,16'h0000,1,3'd3,16'hBEEF), 1'b1, 1'b1, 16'hBEEF, 16'h0000};
    tab[4]  = '{mk(1,3'd5,3'd5,3'd5,1,16'h0505,16'h0505,0,3'd0,16'h0), 1'b1, 1'b1, 16'h0505, 16'h0505};
    tab[5]  = '{mk(1,3'd0,3'd0,3'd5,1,16'h0,16'h0,0,3'd0,16'h0), 1'b1, 1'b1, 16'h0, 16'h0};
    tab[6]  = '{mk(1,3'd0,3'd0,3'd5,1,16'h0,16'h0,0,3'd0,16'h0), 1'b1, 1'b1, 16'h0, 16'h0};
    tab[7]  = '{mk(1,3'd0,3'd0,3'd5,1,16'h0,16'h0,0,3'd0,16'h0), 1'b0, 1'b0, 16'h0, 16'h0};
    tab[8]  = '{mk(1,3'd0,3'd0,3'd5,1,16'h0,16'h0,1,3'd5,16'h5555), 1'b1, 1'b1, 16'h0, 16'h0};
    for (int i = 9; i < 12; i++)
      tab[i] = '{mk(0,3'd0,3'd0,3'd0,0,16'h0,16'h0,1,3'd5,16'h5555), 1'b1, 1'b0, 16'h0, 16'h0};
    tab[12] = '{mk(1,3'd5,3'd0,3'd0,0,16'h5555,16'h0,0,3'd0,16'h0), 1'b1, 1'b1, 16'h5555, 16'h0000};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tab[i].s, r_got);
      check($sformatf("tab%0d_ready", i), 64'(r_got), 64'(tab[i].exp_ready));
      check($sformatf("tab%0d_valid", i), 64'(valid_o), 64'(tab[i].exp_valid));
      if (tab[i].exp_valid)
        check($sformatf("tab%0d_data", i), 64'({d1_o, d2_o}), 64'({tab[i].exp_d1, tab[i].exp_d2}));
      check($sformatf("tab%0d_err", i), 64'(err_o), 64'h0);
    end

    // held output under back-pressure, then flush returns the r4 claim
    do_reset();
    step(mk(1,3'd0,3'd0,3'd4,1,16'h0,16'h0,0,3'd0,16'h0), r_got);
    s = mk(1,3'd4,3'd0,3'd0,0,16'h4444,16'h0,0,3'd0,16'h0);
    s.rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(s, r_got);
      check("hold_ready", 64'(r_got), 64'h0);
      check("hold_out", 64'({valid_o, tgt_o, tgt_en_o}), 64'({1'b1, 3'd4, 1'b1}));
    end
    s = idle(); s.flush = 1'b1; s.rdy = 1'b0;
    step(s, r_got);
    check("flush_valid", 64'(valid_o), 64'h0);
    step(mk(1,3'd4,3'd0,3'd0,0,16'h4444,16'h0,0,3'd0,16'h0), r_got);
    check("flush_unblock", 64'({r_got, d1_o}), 64'({1'b1, 16'h4444}));

    // stray writeback sets sticky error; async reset mid-stall clears everything at once
    do_reset();
    step(mk(0,3'd0,3'd0,3'd0,0,16'h0,16'h0,1,3'd6,16'hABCD), r_got);
    check("err_set", 64'(err_o), 64'h1);
    step(idle(), r_got);
    check("err_sticky", 64'(err_o), 64'h1);
    step(mk(1,3'd0,3'd0,3'd2,1,16'h0,16'h0,0,3'd0,16'h0), r_got);
    s = mk(1,3'd2,3'd0,3'd0,0,16'h0,16'h0,0,3'd0,16'h0);
    s.rdy = 1'b0;
    step(s, r_got);
    check("stall_ready", 64'(r_got), 64'h0);
    drive(s);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 64'({err_o, valid_o, ready_o}), 64'({1'b0, 1'b0, 1'b1}));
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // randomized traffic with a legal writeback stream
    for (int r = 0; r < 8; r++) rf_mem[r] = 16'(r * 16'h1010);
    for (int c = 0; c < 600; c++) begin
      logic killen;
      int   start, cand, kcount;
      s = idle();
      s.valid  = ($urandom_range(3) != 0);
      s.src1   = 3'($urandom_range(7));
      s.src2   = 3'($urandom_range(7));
      s.tgt    = 3'($urandom_range(7));
      s.tgt_en = $urandom_range(1);
      s.flush  = ($urandom_range(7) == 0);
      s.rdy    = ($urandom_range(3) != 0);
      killen   = s.flush && m_valid && m_tgt_en;
      cand     = -1;
      if ($urandom_range(1) == 1) begin
        start = $urandom_range(6);
        for (int k = 0; k < 7; k++) begin
          int r;
          r = 1 + (start + k) % 7;
          kcount = (killen && m_tgt == r) ? 1 : 0;
          if (cand < 0 && pend[r] - kcount > 0) cand = r;
        end
      end
      if (cand > 0) begin
        s.wb_valid = 1'b1; s.wb_tgt = 3'(cand);
      end else if ($urandom_range(5) == 0) begin
        s.wb_valid = 1'b1; s.wb_tgt = 3'd0;
      end
      s.wb_data = 16'($urandom);
      s.rf1 = rf_mem[s.src1];
      s.rf2 = rf_mem[s.src2];
      step(s, r_got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_operand_fetch.md
Name: reg_operand_fetch

Overview:
Initiator side of the RiSC-16 pipelined register file. It owns both register-file read address ports and the write port. It keeps a per-register scoreboard of in-flight writes, stalls issue on RAW hazards, and bypasses same-cycle writeback data. Accepted operand bundles are registered toward the execute stage behind a valid/ready handshake.

Parameters:
p_WORD_LEN, 16, data word width
p_REG_ADDR_LEN, 3, register address width
p_REG_FILE_SIZE, 8, number of architectural registers (r0 hardwired 0)
p_PEND_BITS, 2, width of each scoreboard counter; max in-flight writes per register = 2^p_PEND_BITS-1

Ports:
i_clk  in  1  clock; all state updates on posedge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  decode presents an instruction
o_ready  out  1  instruction accepted on this posedge when i_valid&o_ready
i_src1  in  p_REG_ADDR_LEN  source register 1
i_src2  in  p_REG_ADDR_LEN  source register 2
i_tgt  in  p_REG_ADDR_LEN  destination register
i_tgt_en  in  1  instruction will write i_tgt
o_rf_src1  out  p_REG_ADDR_LEN  register file read address 1 (=i_src1)
o_rf_src2  out  p_REG_ADDR_LEN  register file read address 2 (=i_src2)
i_rf_src1_data  in  p_WORD_LEN  asynchronous read data 1
i_rf_src2_data  in  p_WORD_LEN  asynchronous read data 2
i_wb_valid  in  1  writeback stage retires a write
i_wb_tgt  in  p_REG_ADDR_LEN  writeback register
i_wb_data  in  p_WORD_LEN  writeback data
o_rf_tgt  out  p_REG_ADDR_LEN  register file write address (=i_wb_tgt)
o_rf_tgt_data  out  p_WORD_LEN  register file write data (=i_wb_data)
o_rf_wr_en  out  1  register file write enable (=i_wb_valid)
i_flush  in  1  kill the output slot
o_valid  out  1  operand bundle valid
i_ready  in  1  execute stage consumes the bundle
o_src1_data  out  p_WORD_LEN  operand 1
o_src2_data  out  p_WORD_LEN  operand 2
o_tgt  out  p_REG_ADDR_LEN  destination (forwarded)
o_tgt_en  out  1  destination enable (forwarded)
o_err  out  1  sticky: writeback to a register with zero pending count

Behaviour:
- Reset (async, i_rst_n=0): all counters 0; o_valid, o_err, o_tgt_en = 0; o_src*_data, o_tgt = 0. Takes effect immediately, mid-operation included.
- Write port and read addresses are pure combinational pass-through. The register file writes on the same posedge as the writeback.
- Effective source data: if src==0, then 0. Else if i_wb_valid and i_wb_tgt==src, then i_wb_data (bypass). Else i_rf_srcN_data.
- Source src is blocked when src!=0 and pend[src] - (i_wb_valid & i_wb_tgt==src) > 0.
- Target is blocked when i_tgt_en, i_tgt!=0 and pend[i_tgt] == max, with no same-cycle writeback to i_tgt.
- Slot free: !o_valid | i_ready | i_flush.
- o_ready = !src1 blocked & !src2 blocked & !target blocked & slot free. It is combinational and does not depend on i_valid.
- Accept (i_valid&o_ready) at posedge N: the bundle (effective data, tgt, tgt_en) is registered. o_valid=1 after edge N, giving 1-cycle latency.
- Slot consumed or flushed with no accept: o_valid drops to 0. When o_valid=1 & !i_ready & !i_flush, all outputs are held stable.
- Scoreboard per register r!=0: next = pend + inc - dec - kill.
  - inc: accept with i_tgt_en & i_tgt==r.
  - dec: i_wb_valid & i_wb_tgt==r & pend>0.
  - kill: i_flush & o_valid & o_tgt_en & o_tgt==r (retires the flushed claim).
  - Any combination in one cycle is netted. The result is clamped at 0.
- Hazard checks use the count before this instruction's own claim, so src==tgt of the same instruction is not self-blocking.
- r0: never counted, never blocked. A writeback with tgt 0 still drives o_rf_wr_en; the register file ignores it.
- Writeback to r!=0 with pend==0 (after kill netting): the write still passes through, the counter stays 0, and o_err is set until reset.
- The downstream pipeline must supply exactly one writeback per accepted, unflushed instruction with tgt_en.

Decomposition:
- Shared package risc16_pkg: p_WORD_LEN, p_REG_ADDR_LEN, p_REG_FILE_SIZE, and the operand-bundle struct {src1_data, src2_data, tgt, tgt_en}.
- One sub-module: reg_scoreboard. It holds the counter array, inc/dec/kill netting, and the per-source blocked and target-saturated outputs.
- reg_operand_fetch holds bypass muxing, the handshake and the output slot.

Test Plan:
- Reset then issue src1=1, src2=2 with RF data 0x1111/0x2222 -> o_valid next cycle, data 0x1111/0x2222, o_err=0.
- Issue tgt=3 tgt_en=1, then an instruction with src1=3 -> o_ready=0 until i_wb_valid tgt=3 data 0xBEEF. In that cycle o_ready=1 and o_src1_data=0xBEEF is captured.
- Issue src1=0, src2=0 while RF returns 0xFFFF -> both operands 0, never blocked.
- Three issues to tgt=5 with no writeback -> a fourth to tgt=5 stalls (count 3=max). One wb to r5 in the same cycle lets it accept, and the count stays 3.
- o_valid=1 with o_tgt=4 and i_ready=0 -> outputs held. Assert i_flush -> o_valid=0, pend[4] back to 0, and src=4 is no longer blocked.
- Writeback to r6 with pend[6]=0 -> o_rf_wr_en=1 passes through and o_err=1 sticky. Async reset mid-stall -> o_err=0, o_valid=0 immediately.
